// File: rtl/instr_packer.sv
// instr_packer: packs R/I/J instruction fields into 32-bit words, buffers them in a
// small FIFO and streams them to instruction memory at sequential addresses.
`default_nettype none

module instr_packer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       words_written,
  output logic              err_fmt,
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       packed_word;
  logic              push;
  logic              pop;
  logic              done;

  always_comb begin
    packed_word = 32'h0000_0000;
    case (fmt)
      2'd0:    packed_word = {opcode, rs, rt, rd, shamt, funct};
      2'd1:    packed_word = {opcode, rs, rt, imm16};
      2'd2:    packed_word = {opcode, target};
      default: packed_word = 32'h0000_0000;
    endcase
  end

  // in_ready looks only at the registered count so it never combinationally
  // depends on the memory handshake.
  assign in_ready = (count < DEPTH_CNT);
  assign idle     = (count == '0) && !mem_we;
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (!mem_we || mem_ready);
  assign done     = mem_we && mem_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= packed_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0000_0000;
      next_addr <= '0;
    end else if (pop) begin
      mem_we    <= 1'b1;
      mem_addr  <= next_addr;
      mem_wdata <= fifo_mem[rd_ptr];
      next_addr <= next_addr + ADDR_W'(1);
    end else begin
      if (done) begin
        mem_we <= 1'b0;
      end
      // pop is impossible while idle, so rebasing never races a load
      if (load_base && idle) begin
        next_addr <= base_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_written <= 16'h0000;
      err_fmt       <= 1'b0;
    end else begin
      if (done) begin
        words_written <= words_written + 16'h0001;
      end
      if (push && (fmt == 2'd3)) begin
        err_fmt <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_packer.sv
// tb_instr_packer: directed and randomized checks of instr_packer against a
// queue-based transaction model.
`default_nettype none

module tb_instr_packer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [25:0]       target;
  logic              load_base;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [15:0]       words_written;
  logic              err_fmt;
  logic              idle;

  instr_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .target(target), .load_base(load_base),
    .base_addr(base_addr), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .words_written(words_written),
    .err_fmt(err_fmt), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction model: words waiting in the buffer, plus the one held at the port.
  logic [31:0]       m_q[$];
  logic              m_out_full;
  logic [ADDR_W-1:0] m_out_addr;
  logic [31:0]       m_out_data;
  logic [ADDR_W-1:0] m_next;
  logic [15:0]       m_ww;
  logic              m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_word();
    logic [31:0] w;
    case (fmt)
      2'd0: w = (32'(opcode) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
                (32'(rd) << 11) | (32'(shamt) << 6) | 32'(funct);
      2'd1: w = (32'(opcode) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm16);
      2'd2: w = (32'(opcode) << 26) | 32'(target);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_out_full = 1'b0;
    m_out_addr = '0;
    m_out_data = 32'h0;
    m_next     = '0;
    m_ww       = 16'h0;
    m_err      = 1'b0;
  endtask

  task automatic verify();
    check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    check("mem_we", 32'(mem_we), 32'(m_out_full));
    check("idle", 32'(idle), 32'((m_q.size() == 0) && !m_out_full));
    check("words_written", 32'(words_written), 32'(m_ww));
    check("err_fmt", 32'(err_fmt), 32'(m_err));
    if (m_out_full) begin
      check("mem_addr", 32'(mem_addr), 32'(m_out_addr));
      check("mem_wdata", mem_wdata, m_out_data);
    end
  endtask

  // Advance model and DUT one clock with the currently driven inputs.
  task automatic cycle();
    bit was_idle, can_push, can_load, completes;
    was_idle  = (m_q.size() == 0) && !m_out_full;
    can_push  = in_valid && (m_q.size() < DEPTH);
    can_load  = (m_q.size() != 0) && (!m_out_full || mem_ready);
    completes = m_out_full && mem_ready;
    if (completes) m_ww = m_ww + 16'h1;
    if (load_base && was_idle) m_next = base_addr;
    if (can_load) begin
      m_out_data = m_q.pop_front();
      m_out_addr = m_next;
      m_next     = m_next + ADDR_W'(1);
      m_out_full = 1'b1;
    end else if (completes) begin
      m_out_full = 1'b0;
    end
    if (can_push) begin
      m_q.push_back(pack_word());
      if (fmt == 2'd3) m_err = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    verify();
  endtask

  task automatic rand_fields(input int fmt_max);
    fmt    = 2'($urandom_range(0, fmt_max));
    opcode = 6'($urandom);
    rs     = 5'($urandom);
    rt     = 5'($urandom);
    rd     = 5'($urandom);
    shamt  = 5'($urandom);
    funct  = 6'($urandom);
    imm16  = 16'($urandom);
    target = 26'($urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    load_base = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; load_base = 1'b0; base_addr = '0; mem_ready = 1'b0;
    fmt = 2'd0; opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    imm16 = '0; target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset words_written", 32'(words_written), 32'd0);
    check("reset err_fmt", 32'(err_fmt), 32'd0);
    check("reset idle", 32'(idle), 32'd1);
    rst_n = 1'b1;

    // R-type add
    fmt = 2'd0; opcode = 6'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; funct = 6'h20;
    in_valid = 1'b1; mem_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("rtype wdata", mem_wdata, 32'h0022_1820);
    check("rtype addr", 32'(mem_addr), 32'd0);
    check("rtype we", 32'(mem_we), 32'd1);
    cycle();
    check("rtype count", 32'(words_written), 32'd1);
    drain();

    // lw then j, rebased to address 0
    fmt = 2'd1; opcode = 6'h23; rs = 5'd29; rt = 5'd8; imm16 = 16'd4;
    in_valid = 1'b1; load_base = 1'b1; base_addr = '0;
    cycle();
    load_base = 1'b0;
    fmt = 2'd2; opcode = 6'd2; target = 26'h10;
    cycle();
    check("lw wdata", mem_wdata, 32'h8FA8_0004);
    check("lw addr", 32'(mem_addr), 32'd0);
    in_valid = 1'b0;
    cycle();
    check("j wdata", mem_wdata, 32'h0800_0010);
    check("j addr", 32'(mem_addr), 32'd1);
    drain();

    // Backpressure: six offered, five accepted
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_fields(2);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    check("bp in_ready", 32'(in_ready), 32'd0);
    check("bp held we", 32'(mem_we), 32'd1);
    begin
      logic [15:0] ww0;
      ww0 = words_written;
      mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      check("bp five written", 32'(words_written - ww0), 32'd5);
    end
    cycle();
    check("bp drained", 32'(idle), 32'd1);
    drain();

    // Base load near the top, wrap, and ignored load_base while busy
    load_base = 1'b1; base_addr = 10'h3FF;
    cycle();
    rand_fields(2); in_valid = 1'b1; load_base = 1'b0;
    cycle();
    rand_fields(2); load_base = 1'b1; base_addr = 10'h123;
    cycle();
    check("base addr", 32'(mem_addr), 32'h3FF);
    in_valid = 1'b0; load_base = 1'b0;
    cycle();
    check("wrap addr", 32'(mem_addr), 32'h000);
    drain();

    // Reserved fmt
    rand_fields(2); fmt = 2'd3; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("fmt3 wdata", mem_wdata, 32'h0);
    check("fmt3 err", 32'(err_fmt), 32'd1);
    drain();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rand_fields(2);
      if ($urandom_range(0, 15) == 0) fmt = 2'd3;
      in_valid  = ($urandom_range(0, 3) != 0);
      load_base = ($urandom_range(0, 7) == 0);
      base_addr = ADDR_W'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    load_base = 1'b0;

    // Asynchronous reset with words pending
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_fields(2);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    check("pre-reset busy", 32'(idle), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async mem_we", 32'(mem_we), 32'd0);
    check("async idle", 32'(idle), 32'd1);
    check("async in_ready", 32'(in_ready), 32'd1);
    check("async mem_addr", 32'(mem_addr), 32'd0);
    check("async words", 32'(words_written), 32'd0);
    check("async err", 32'(err_fmt), 32'd0);
    model_reset();
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("post-reset words", 32'(words_written), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_packer.md
INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  4  word FIFO entries (power of 2, >=2)
  ADDR_W  10  instruction memory address width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state changes on posedge
  rst_n  in  1  reset, asynchronous, active-low
  in_valid  in  1  field bundle valid
  in_ready  out  1  packer can accept a bundle
  fmt  in  2  0=R, 1=I, 2=J, 3=reserved
  opcode  in  6  opcode field
  rs, rt, rd  in  5 each  register fields
  shamt  in  5  shift amount
  funct  in  6  function field
  imm16  in  16  I-type immediate
  target  in  26  J-type target
  load_base  in  1  load base_addr as next write address
  base_addr  in  ADDR_W  new start address
  mem_we  out  1  write request to instruction memory
  mem_ready  in  1  memory accepts the write this cycle
  mem_addr  out  ADDR_W  write address
  mem_wdata  out  32  packed instruction word
  words_written  out  16  count of completed memory writes
  err_fmt  out  1  sticky: a reserved fmt was accepted
  idle  out  1  FIFO empty and no pending write

Function
REQ-003 Acceptance SHALL occur on a posedge where in_valid=1 and in_ready=1; a bundle SHALL never be dropped or duplicated.
REQ-004 in_ready SHALL be 1 iff FIFO count < DEPTH; it SHALL NOT depend on same-cycle pops.
REQ-005 The packed word SHALL be: R = {opcode,rs,rt,rd,shamt,funct}; I = {opcode,rs,rt,imm16}; J = {opcode,target}; bit 31 is the opcode MSB.
REQ-006 fmt=3 SHALL push 32'h00000000 and set err_fmt, which stays 1 until reset.
REQ-007 FIFO SHALL be DEPTH-deep, in order; read/write pointers SHALL wrap modulo DEPTH.
REQ-008 The output stage (mem_we/mem_addr/mem_wdata) SHALL be registered; it SHALL load the FIFO head on a posedge where the FIFO is non-empty and (mem_we=0 or mem_ready=1).
REQ-009 While mem_we=1 and mem_ready=0, mem_addr and mem_wdata SHALL hold stable.
REQ-010 A write completes on a posedge with mem_we=1 and mem_ready=1; if no new head is loaded on that edge, mem_we SHALL drop to 0.
REQ-011 Latency: with the FIFO empty and mem_we=0, a bundle accepted at edge k SHALL give mem_we=1 with its word after edge k+1; back-to-back writes with mem_ready=1 SHALL sustain one write per cycle.
REQ-012 mem_addr of each loaded word SHALL equal the next-address counter, which increments by 1 per load and wraps from 2^ADDR_W-1 to 0.
REQ-013 load_base SHALL set the next-address counter to base_addr only when idle=1; when idle=0 it SHALL be ignored.
REQ-014 words_written SHALL increment by 1 per completed write and wrap from 16'hFFFF to 0.
REQ-015 Simultaneous push and pop in one cycle SHALL leave count unchanged; a push at count=DEPTH-1 with a pop SHALL keep in_ready=1.
REQ-016 idle SHALL be 1 iff FIFO count=0 and mem_we=0.

Reset
REQ-017 rst_n=0 SHALL immediately, without a clock, force: FIFO empty, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, next address=0, words_written=0, err_fmt=0, idle=1.
REQ-018 Reset mid-write SHALL discard all buffered and pending words; no write SHALL complete on or after the reset assertion.

Verification
REQ-019 R-type: opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, mem_ready=1 -> after one cycle, mem_wdata=0x00221820, mem_addr=0, mem_we=1; words_written=1 after the next edge.
REQ-020 I/J: lw (opcode=0x23, rs=29, rt=8, imm16=4) then j (opcode=2, target=0x10) -> 0x8FA80004 @addr 0, then 0x08000010 @addr 1.
REQ-021 Backpressure: mem_ready=0, push 6 bundles -> in_ready=0 once 4 words are in the FIFO and a fifth is held in the output stage; the output holds; raise mem_ready -> all 5 written in order, one per cycle.
REQ-022 Base/wrap: idle, load_base with base_addr=0x3FF, push 2 -> addresses 0x3FF, 0x000; load_base while busy -> ignored.
REQ-023 fmt=3 push -> word 0x00000000 written, err_fmt=1 until rst_n=0.
REQ-024 Assert rst_n=0 with 3 words pending, mem_ready=0 -> mem_we=0 and idle=1 asynchronously; no further writes after release.
